// File: rtl/seg_scan_driver_if.sv
// Bus between a host and the 7-segment scanner: load strobe and data in,
// digit code, anodes, decimal point and frame tick out.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    lz_suppress;
    logic [3:0]              digit_code;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    dp_n;
    logic                    frame_tick;

    modport master (
        output load, value, dp_mask, lz_suppress,
        input  digit_code, an_n, dp_n, frame_tick
    );

    modport slave (
        input  load, value, dp_mask, lz_suppress,
        output digit_code, an_n, dp_n, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered
// value loading, leading-zero blanking and per-slot anti-ghosting guard.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;
    logic                    r_wrap;
    logic [3:0]              r_digit_code;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic                    r_dp_n;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_suppress;
    logic                    w_active;
    logic [3:0]              w_nibble;
    logic [NUM_DIGITS-1:0]   w_anode;

    assign w_slot_end  = (r_presc == PRESC_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_frame_end;
            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // A load landing on the frame-end cycle bypasses the pending buffer and
    // supersedes whatever was pending, so the newest value is always shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_disp_dp    <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_frame_end) begin
            r_pend_valid <= 1'b0;
            if (bus.load) begin
                r_disp    <= bus.value;
                r_disp_dp <= bus.dp_mask;
            end else if (r_pend_valid) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
        end else if (bus.load) begin
            r_pend       <= bus.value;
            r_pend_dp    <= bus.dp_mask;
            r_pend_valid <= 1'b1;
        end
    end

    // Digit i is blank when it and every more-significant nibble are zero;
    // digit 0 is never considered so a zero value still shows one "0".
    always_comb begin
        w_upper_zero = 1'b1;
        w_suppress   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_upper_zero  = w_upper_zero && (r_disp[i*4 +: 4] == 4'h0);
            w_suppress[i] = bus.lz_suppress && w_upper_zero;
        end
    end

    assign w_active = (r_presc >= GUARD_END) && !w_suppress[r_idx];
    assign w_nibble = r_disp[r_idx*4 +: 4];
    assign w_anode  = ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_code <= 4'h0;
            r_an_n       <= '1;
            r_dp_n       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_digit_code <= w_nibble;
            r_an_n       <= w_active ? w_anode : '1;
            r_dp_n       <= w_active ? ~r_disp_dp[r_idx] : 1'b1;
            r_frame_tick <= r_wrap;
        end
    end

    assign bus.digit_code = r_digit_code;
    assign bus.an_n       = r_an_n;
    assign bus.dp_n       = r_dp_n;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scanner for a bank of common-anode 7-segment digits that share one segment bus.
- Latches a packed hex value (PC, register contents, debug word) and steps through the digits one at a time.
- Each slot presents one 4-bit digit code to the downstream hex-to-7-segment decoder and drives the matching active-low anode and decimal point.
- Digit-blanking is done entirely through the anodes, because the decoder has no blank code.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16).
- PRESCALE, 50000, clk cycles per digit slot (>= GUARD+2).
- GUARD, 16, cycles at the start of each slot with all anodes off (anti-ghosting, >= 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  one-cycle strobe; capture value/dp_mask
- value  input  4*NUM_DIGITS  packed nibbles; nibble 0 is the rightmost digit
- dp_mask  input  NUM_DIGITS  1 = light decimal point of digit i
- lz_suppress  input  1  1 = blank leading zero digits
- digit_code  output  4  nibble to downstream decoder
- an_n  output  NUM_DIGITS  active-low anode enables, at most one low
- dp_n  output  1  active-low decimal point for the current digit
- frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- Port names are clk and rst_n.

Reset (rst_n low, asynchronous):
- Prescaler = 0, digit index = 0.
- Display and pending registers = 0; pending flag = 0.
- digit_code = 0, an_n = all ones, dp_n = 1, frame_tick = 0.

Prescaler and digit index:
- Prescaler counts 0..PRESCALE-1 and wraps.
- On wrap, the digit index increments; NUM_DIGITS-1 wraps to 0.
- The index-0 transition is the frame boundary.

Loading (double-buffered, no tearing):
- load captures value and dp_mask into the pending registers and sets pending.
- A later load before commit overwrites pending; last write wins.
- At a frame boundary with pending set, pending is copied to the display registers and the flag clears.
- If load coincides with the frame-boundary cycle, the incoming value commits directly to the display registers and pending clears. Any older pending value is discarded.
- Display registers change only at frame boundaries, never mid-frame.

Outputs (registered; one cycle behind the counter state):
- digit_code = display nibble[index].
- an_n: all ones while prescaler < GUARD. Otherwise bit[index] = 0 unless the digit is suppressed.
- Digit i is suppressed when lz_suppress = 1, i != 0, and nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never suppressed, so a value of 0 shows a single "0".
- dp_n = ~dp_mask_disp[index] when the anode is active; otherwise 1.
- frame_tick = 1 for exactly one cycle, on the cycle after the index becomes 0.
- lz_suppress is sampled live, not double-buffered.

Reset mid-operation:
- Immediate return to the reset state; pending data is lost.
- Scanning restarts at digit 0, and the first anode goes low GUARD+1 cycles after rst_n rises.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE=4, GUARD=1.)
1. Reset check: assert rst_n = 0 mid-slot -> an_n = 4'b1111, dp_n = 1, digit_code = 0 within the same cycle (asynchronous). After release, an_n[0] goes low on cycle 2.
2. Basic scan: load value = 16'h12AB, dp_mask = 0 -> after the next frame boundary, digit_code sequence is B, A, 2, 1. Each is accompanied by an_n 1110, 1101, 1011, 0111, each low for 3 of 4 cycles. frame_tick pulses every 16 cycles.
3. Leading-zero suppression: load 16'h0050 with lz_suppress = 1 -> digits 3 and 2 keep an_n high; digits 1 (5) and 0 (0) are lit. load 16'h0000 -> only digit 0 is lit. With lz_suppress = 0, all four digits are lit.
4. No tearing: load 16'h1111, then load 16'h2222 while digit 2 is displayed -> the remainder of the frame still shows 1, and the next frame shows 2222.
5. Simultaneous events: load 16'h3333 then 16'h4444 in consecutive cycles mid-frame -> next frame shows 4444. A load of 16'h5555 on the boundary cycle -> 5555 is shown starting at digit 0 of that frame.
6. Decimal point: dp_mask = 4'b0100 -> dp_n = 0 only while an_n = 4'b1011, and dp_n = 1 during guard cycles.
